// File: rtl/gcn_engine.sv
// gcn_engine: single-layer GCN inference core, per-node argmax((A[+I]) * (X * W)).
// Define GCN_SELF_LOOP_EN to seed aggregation with each node's own transformed row (A+I).
`timescale 1ns/1ps

module gcn_engine #(
  parameter int NUM_NODES      = 6,
  parameter int FEATURE_COLS   = 96,
  parameter int NUM_CLASSES    = 3,
  parameter int NUM_EDGES      = 6,
  parameter int FEATURE_WIDTH  = 5,
  parameter int WEIGHT_WIDTH   = 5,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int FEATURE_BASE   = 512,
  parameter int NODE_BW        = (NUM_NODES   > 1) ? $clog2(NUM_NODES)   : 1,
  parameter int EDGE_BW        = (NUM_EDGES   > 1) ? $clog2(NUM_EDGES)   : 1,
  parameter int CLASS_BW       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  parameter int DW             = (FEATURE_WIDTH > WEIGHT_WIDTH) ? FEATURE_WIDTH : WEIGHT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DW-1:0]            data_in [FEATURE_COLS],
  input  logic [NODE_BW-1:0]       coo_in [2],
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     enable_read,
  output logic [EDGE_BW-1:0]       coo_address,
  output logic                     done,
  output logic [CLASS_BW-1:0]      max_addi_answer [NUM_NODES]
);

  localparam int DPW    = DOT_PROD_WIDTH;
  localparam int MAX_CE = (NUM_CLASSES > NUM_EDGES) ? NUM_CLASSES : NUM_EDGES;
  localparam int MAX_PH = (MAX_CE > NUM_NODES) ? MAX_CE : NUM_NODES;
  localparam int CNT_W  = $clog2(MAX_PH + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_C = CNT_W'(NUM_CLASSES);
  localparam logic [CNT_W-1:0] CNT_N = CNT_W'(NUM_NODES);
  localparam logic [CNT_W-1:0] CNT_E = CNT_W'(NUM_EDGES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_XFORM, S_AGG, S_ARGMAX, S_DONE} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [WEIGHT_WIDTH-1:0] r_wreg [NUM_CLASSES][FEATURE_COLS];
  logic [DPW-1:0]          r_fw   [NUM_NODES][NUM_CLASSES];
  logic [DPW-1:0]          r_adj  [NUM_NODES][NUM_CLASSES];

  logic [DPW-1:0]          w_dot     [NUM_CLASSES];
  logic [DPW-1:0]          w_adj_inc [NUM_NODES][NUM_CLASSES];
  logic [NODE_BW-1:0]      w_src, w_dst, w_s, w_d, w_node;
  logic                    w_edge_ok;
  logic [CLASS_BW-1:0]     w_best_cls;
  logic [DPW-1:0]          w_best_val;

  // One dot product per class against the feature row currently on data_in.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_dot
    logic [DPW-1:0] w_acc;
    always_comb begin
      w_acc = '0;
      for (int k = 0; k < FEATURE_COLS; k++)
        w_acc = w_acc + DPW'(data_in[k][FEATURE_WIDTH-1:0]) * DPW'(r_wreg[gi][k]);
    end
    assign w_dot[gi] = w_acc;
  end

  assign w_src     = coo_in[0];
  assign w_dst     = coo_in[1];
  assign w_edge_ok = (32'(w_src) < 32'(NUM_NODES)) && (32'(w_dst) < 32'(NUM_NODES));
  // Out-of-range indices are clamped so the fw lookup never leaves the array.
  assign w_s       = w_edge_ok ? w_src : '0;
  assign w_d       = w_edge_ok ? w_dst : '0;

  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_adj_node
    for (genvar gj = 0; gj < NUM_CLASSES; gj++) begin : g_adj_cls
      logic [DPW-1:0] w_add;
      always_comb begin
        w_add = '0;
        if (w_edge_ok && (w_d == NODE_BW'(gi)))
          w_add = w_add + r_fw[w_s][gj];
        if (w_edge_ok && (w_s == NODE_BW'(gi)) && (w_s != w_d))
          w_add = w_add + r_fw[w_d][gj];
      end
      assign w_adj_inc[gi][gj] = r_adj[gi][gj] + w_add;
    end
  end

  // Strict greater-than keeps the lowest class index on ties.
  assign w_node = r_cnt[NODE_BW-1:0];
  always_comb begin
    w_best_cls = '0;
    w_best_val = r_adj[w_node][0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (r_adj[w_node][c] > w_best_val) begin
        w_best_val = r_adj[w_node][c];
        w_best_cls = CLASS_BW'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      read_address <= '0;
      enable_read  <= 1'b0;
      coo_address  <= '0;
      done         <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) begin
        max_addi_answer[n] <= '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
          r_fw[n][c]  <= '0;
          r_adj[n][c] <= '0;
        end
      end
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int k = 0; k < FEATURE_COLS; k++)
          r_wreg[c][k] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_LOAD_W;
            r_cnt        <= '0;
            read_address <= '0;
            enable_read  <= 1'b1;
            done         <= 1'b0;
            for (int n = 0; n < NUM_NODES; n++) begin
              max_addi_answer[n] <= '0;
              for (int c = 0; c < NUM_CLASSES; c++)
                r_adj[n][c] <= '0;
            end
          end
        end
        S_LOAD_W: begin
          // Data for the address shown in cycle j arrives in cycle j+1.
          for (int c = 0; c < NUM_CLASSES; c++)
            if (r_cnt == CNT_W'(c + 1))
              for (int k = 0; k < FEATURE_COLS; k++)
                r_wreg[c][k] <= data_in[k][WEIGHT_WIDTH-1:0];
          if (r_cnt == CNT_C) begin
            r_state      <= S_XFORM;
            r_cnt        <= '0;
            read_address <= ADDRESS_WIDTH'(FEATURE_BASE);
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt < CNT_C - 1'b1)
              read_address <= read_address + 1'b1;
          end
        end
        S_XFORM: begin
          for (int n = 0; n < NUM_NODES; n++)
            if (r_cnt == CNT_W'(n + 1))
              for (int c = 0; c < NUM_CLASSES; c++)
                r_fw[n][c] <= w_dot[c];
          if (r_cnt == CNT_N) begin
            r_state     <= S_AGG;
            r_cnt       <= '0;
            coo_address <= '0;
            for (int n = 0; n < NUM_NODES; n++)
              for (int c = 0; c < NUM_CLASSES; c++)
`ifdef GCN_SELF_LOOP_EN
                // The last row is still being captured this cycle, so take it from the adder.
                r_adj[n][c] <= (n == NUM_NODES - 1) ? w_dot[c] : r_fw[n][c];
`else
                r_adj[n][c] <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt < CNT_N - 1'b1)
              read_address <= read_address + 1'b1;
            else
              enable_read <= 1'b0;
          end
        end
        S_AGG: begin
          if (r_cnt != '0)
            for (int n = 0; n < NUM_NODES; n++)
              for (int c = 0; c < NUM_CLASSES; c++)
                r_adj[n][c] <= w_adj_inc[n][c];
          if (r_cnt == CNT_E) begin
            r_state <= S_ARGMAX;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt < CNT_E - 1'b1)
              coo_address <= coo_address + 1'b1;
          end
        end
        S_ARGMAX: begin
          max_addi_answer[w_node] <= w_best_cls;
          if (r_cnt == CNT_N - 1'b1) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_engine.sv
// tb_gcn_engine: directed runs of gcn_engine with a done-triggered scoreboard monitor.
// Memory models answer FM/WM and COO reads one cycle after the request.
`timescale 1ns/1ps

module tb_gcn_engine;
  localparam int NN  = 6;
  localparam int FC  = 96;
  localparam int NC  = 3;
  localparam int NE  = 6;
  localparam int LAT = NC + NN + NE + NN + 4;
`ifdef GCN_SELF_LOOP_EN
  localparam int T3_N3 = 2;
  localparam int T5_N2 = 2;
`else
  localparam int T3_N3 = 0;
  localparam int T5_N2 = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  data_in [FC];
  logic [2:0]  coo_in [2];
  logic [12:0] read_address;
  logic        enable_read;
  logic [2:0]  coo_address;
  logic        done;
  logic [1:0]  max_addi_answer [NN];

  gcn_engine dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .coo_in(coo_in),
    .read_address(read_address), .enable_read(enable_read), .coo_address(coo_address),
    .done(done), .max_addi_answer(max_addi_answer)
  );

  always #5 clk = ~clk;

  int         wcol [NC][FC];
  int         feat [NN][FC];
  logic [2:0] esrc [NE];
  logic [2:0] edst [NE];
  int         cyc = 0;
  int         ra;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    ra = int'(read_address);
    if (enable_read) begin
      for (int k = 0; k < FC; k++) begin
        if (ra < NC)                      data_in[k] <= 5'(wcol[ra][k]);
        else if (ra >= 512 && ra < 512+NN) data_in[k] <= 5'(feat[ra-512][k]);
        else                              data_in[k] <= '0;
      end
    end
    coo_in[0] <= esrc[coo_address];
    coo_in[1] <= edst[coo_address];
  end

  typedef struct { int due; logic [11:0] ans; int id; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic done_q  = 1'b0;

  function automatic logic [11:0] pack_ans();
    logic [11:0] p;
    for (int n = 0; n < NN; n++) p[2*n +: 2] = max_addi_answer[n];
    return p;
  endfunction

  function automatic logic [11:0] mk(input int a0, a1, a2, a3, a4, a5);
    return {2'(a5), 2'(a4), 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every rising done pops one expected run.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", cyc, mon_e.due);
        for (int n = 0; n < NN; n++)
          check("answer", 32'(max_addi_answer[n]), 32'(mon_e.ans[2*n +: 2]));
        $display("[TB] run %0d: done at cycle %0d (expected %0d), answers %h (expected %h)",
                 mon_e.id, cyc, mon_e.due, pack_ans(), mon_e.ans);
      end
    end
    done_q <= done;
  end

  task automatic set_edge(input int e, input int s, input int d);
    esrc[e] = 3'(s);
    edst[e] = 3'(d);
  endtask

  task automatic cfg(input int t);
    for (int c = 0; c < NC; c++) for (int k = 0; k < FC; k++) wcol[c][k] = 0;
    for (int n = 0; n < NN; n++) for (int k = 0; k < FC; k++) feat[n][k] = 0;
    for (int e = 0; e < NE; e++) set_edge(e, 0, 1);
    case (t)
      1: begin
        for (int c = 0; c < NC; c++) for (int k = 0; k < FC; k++) wcol[c][k] = c + 1;
        for (int n = 0; n < NN; n++) for (int k = 0; k < FC; k++) feat[n][k] = 1;
        for (int e = 0; e < NE; e++) set_edge(e, e, (e + 1) % NN);
      end
      2: begin
        for (int k = 0; k < FC; k++) begin wcol[0][k] = 1; wcol[1][k] = 1; end
        for (int n = 0; n < NN; n++) for (int k = 0; k < FC; k++) feat[n][k] = 1;
        set_edge(0, 0, 1); set_edge(1, 1, 2); set_edge(2, 2, 3);
        set_edge(3, 3, 4); set_edge(4, 4, 0); set_edge(5, 0, 2);
      end
      3: begin
        for (int k = 0; k < FC; k++) begin wcol[0][k] = 31; wcol[1][k] = 1; wcol[2][k] = 2; end
        for (int k = 0; k < FC; k++) begin
          feat[0][k] = 1; feat[2][k] = 1; feat[4][k] = 1; feat[5][k] = 1;
          feat[1][k] = (k < 60) ? 6 : 5;
          feat[3][k] = (k < 24) ? 12 : 11;
        end
        set_edge(0, 3, 3);
        set_edge(1, 7, 0);
      end
      default: begin
        for (int k = 1; k < FC; k++) begin wcol[0][k] = 1; wcol[1][k] = 2; end
        wcol[2][0] = 5;
        for (int k = 0; k < FC; k++) begin feat[0][k] = 1; feat[1][k] = 1; end
        feat[2][0] = 1;
      end
    endcase
  endtask

  task automatic run(input int id, input logic [11:0] ans, input bit pulse);
    int s;
    int t;
    exp_t e;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; s = cyc; start = 1'b0;
    e.due = s + LAT - 1; e.ans = ans; e.id = id;
    exp_q.push_back(e);
    if (pulse) begin
      repeat (5) @(posedge clk);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("run_timeout", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("done_hold", {19'd0, done, pack_ans()}, {19'd0, 1'b1, ans});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cfg(1);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {2'd0, done, enable_read, read_address, coo_address, pack_ans()}, 0);
    end

    cfg(1); run(1, mk(2, 2, 2, 2, 2, 2), 1'b0);
    cfg(2); run(2, mk(0, 0, 0, 0, 0, 0), 1'b0);
    cfg(3); run(3, mk(2, 0, 0, T3_N3, 0, 0), 1'b0);

    // Abort a run in its third aggregation cycle.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    check("agg_coo_addr", 32'(coo_address), 32'd2);
    reset = 1'b1;
    #1;
    check("reset_async", {2'd0, done, enable_read, read_address, coo_address, pack_ans()}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", {30'd0, done, enable_read}, 0);
    end

    run(4, mk(2, 0, 0, T3_N3, 0, 0), 1'b1);
    cfg(5); run(5, mk(1, 1, T5_N2, 0, 0, 0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
